// File: rtl/ntt_stage_ctrl_pkg.sv
// rtl/ntt_stage_ctrl_pkg.sv - shared constants and state encoding for the NTT stage sequencer
package ntt_stage_ctrl_pkg;

  localparam int DEF_LOGN    = 8;
  localparam int DEF_BFU_LAT = 4;
  localparam int RING_SIZE   = 1 << DEF_LOGN;
  localparam int STAGE_BNUM  = RING_SIZE / 2;
  localparam int STAGE_W     = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Butterflies issued per stage for a given ring size exponent.
  function automatic int stage_bnum_of(input int logn);
    return 1 << (logn - 1);
  endfunction

endpackage

// File: rtl/ntt_stage_ctrl_wb_delay_line.sv
// rtl/ntt_stage_ctrl_wb_delay_line.sv - fixed-depth shift register that mirrors the BFU pipeline latency
module wb_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// rtl/ntt_stage_ctrl.sv - stage/butterfly sequencer for the in-place ping-pong NTT datapath
module ntt_stage_ctrl
  import ntt_stage_ctrl_pkg::*;
#(
  parameter int LOGN    = DEF_LOGN,
  parameter int BFU_LAT = DEF_BFU_LAT,
  parameter int AW      = LOGN - 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               hold,
  output logic               busy,
  output logic               done,
  output logic [STAGE_W-1:0] stage,
  output logic [AW-1:0]      bfly_idx,
  output logic               issue_valid,
  output logic [LOGN-1:0]    tw_addr,
  output logic               wb_valid,
  output logic [AW-1:0]      wb_idx,
  output logic               rd_bank,
  output logic               wr_bank,
  output logic               result_bank
);

  localparam int                 DW         = (BFU_LAT > 1) ? $clog2(BFU_LAT) : 1;
  localparam logic [AW-1:0]      BFLY_LAST  = AW'(stage_bnum_of(LOGN) - 1);
  localparam logic [DW-1:0]      DRAIN_LAST = DW'(BFU_LAT - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOGN);
  localparam logic               RB_RST     = 1'(LOGN % 2);

  state_t          state, state_d;
  logic [DW-1:0]   drain_cnt;
  logic            run_init, bfly_step, drain_step, stage_adv;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d     = state;
    busy        = 1'b1;
    done        = 1'b0;
    issue_valid = 1'b0;
    run_init    = 1'b0;
    bfly_step   = 1'b0;
    drain_step  = 1'b0;
    stage_adv   = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          run_init = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!hold) begin
          issue_valid = 1'b1;
          bfly_step   = 1'b1;
          if (bfly_idx == BFLY_LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_step = 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          if (stage == STAGE_LAST) begin
            state_d = S_DONE;
          end else begin
            // Stage and bank flip on entry to NEXT so NEXT already shows the new stage.
            stage_adv = 1'b1;
            state_d   = S_NEXT;
          end
        end
      end
      S_NEXT:  state_d = S_ISSUE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage       <= STAGE_W'(1);
      bfly_idx    <= '0;
      rd_bank     <= 1'b0;
      drain_cnt   <= '0;
      result_bank <= RB_RST;
    end else begin
      if (run_init) begin
        stage    <= STAGE_W'(1);
        bfly_idx <= '0;
        rd_bank  <= 1'b0;
      end
      if (bfly_step)
        bfly_idx <= (bfly_idx == BFLY_LAST) ? '0 : bfly_idx + 1'b1;
      if (drain_step)
        drain_cnt <= (drain_cnt == DRAIN_LAST) ? '0 : drain_cnt + 1'b1;
      if (stage_adv) begin
        stage   <= stage + 1'b1;
        rd_bank <= ~rd_bank;
      end
      if (done) result_bank <= ~rd_bank;
    end
  end

  assign wr_bank = ~rd_bank;

  // Twiddle for stage s: 2^(s-1) + (j >> (LOGN-s)); peaks at 2^s-1 so LOGN bits suffice.
  logic [STAGE_W-1:0] tw_shift;
  logic [LOGN-1:0]    tw_base, tw_off;

  always_comb begin
    tw_shift = STAGE_W'(LOGN) - stage;
    tw_base  = LOGN'(1) << (stage - 1'b1);
    tw_off   = LOGN'(bfly_idx >> tw_shift);
    tw_addr  = (state == S_ISSUE) ? tw_base + tw_off : '0;
  end

  wb_delay_line #(
    .DEPTH (BFU_LAT),
    .WIDTH (AW + 1)
  ) u_wb_delay (
    .clk   (clk),
    .reset (reset),
    .din   ({issue_valid, bfly_idx}),
    .dout  ({wb_valid, wb_idx})
  );

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// tb/tb_ntt_stage_ctrl.sv - directed self-checking bench for ntt_stage_ctrl at LOGN=8, BFU_LAT=4
module tb_ntt_stage_ctrl;

  localparam int MAXC = 1100;

  logic       clk = 1'b0;
  logic       reset, start, hold;
  logic       busy, done, issue_valid, wb_valid, rd_bank, wr_bank, result_bank;
  logic [4:0] stage;
  logic [6:0] bfly_idx, wb_idx;
  logic [7:0] tw_addr;

  int n_cmp = 0;
  int n_bad = 0;

  logic       ob_iv [MAXC];
  logic       ob_busy [MAXC];
  logic       ob_done [MAXC];
  logic       ob_wb [MAXC];
  logic       ob_rd [MAXC];
  logic       ob_wr [MAXC];
  logic       ob_rb [MAXC];
  logic [4:0] ob_stage [MAXC];
  logic [6:0] ob_idx [MAXC];
  logic [6:0] ob_wbidx [MAXC];
  logic [7:0] ob_tw [MAXC];

  ntt_stage_ctrl #(.LOGN(8), .BFU_LAT(4), .AW(7)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .hold        (hold),
    .busy        (busy),
    .done        (done),
    .stage       (stage),
    .bfly_idx    (bfly_idx),
    .issue_valid (issue_valid),
    .tw_addr     (tw_addr),
    .wb_valid    (wb_valid),
    .wb_idx      (wb_idx),
    .rd_bank     (rd_bank),
    .wr_bank     (wr_bank),
    .result_bank (result_bank)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the cycle in which the first start is presented; inputs change 1 time unit after posedge.
  task automatic run(input int ncyc, input int hlo, input int hhi,
                     input int s1, input int s2, input int s3, input int rst_c);
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0) || (c == s1) || (c == s2) || (c == s3);
      hold  = (c >= hlo) && (c <= hhi);
      reset = (c != rst_c);
      @(negedge clk);
      ob_iv[c] = issue_valid;  ob_busy[c] = busy;     ob_done[c] = done;
      ob_wb[c] = wb_valid;     ob_rd[c] = rd_bank;    ob_wr[c] = wr_bank;
      ob_rb[c] = result_bank;  ob_stage[c] = stage;   ob_idx[c] = bfly_idx;
      ob_wbidx[c] = wb_idx;    ob_tw[c] = tw_addr;
      @(posedge clk); #1;
    end
    start = 1'b0; hold = 1'b0; reset = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; hold = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; hold = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b expected 0", done); end
    n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL rst_issue_valid: got %b expected 0", issue_valid); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wb_valid: got %b expected 0", wb_valid); end
    n_cmp++; if (tw_addr !== 8'd0) begin n_bad++; $display("FAIL rst_tw_addr: got %0d expected 0", tw_addr); end
    n_cmp++; if (wb_idx !== 7'd0) begin n_bad++; $display("FAIL rst_wb_idx: got %0d expected 0", wb_idx); end
    n_cmp++; if (stage !== 5'd1) begin n_bad++; $display("FAIL rst_stage: got %0d expected 1", stage); end
    n_cmp++; if (bfly_idx !== 7'd0) begin n_bad++; $display("FAIL rst_bfly_idx: got %0d expected 0", bfly_idx); end
    n_cmp++; if (rd_bank !== 1'b0 || wr_bank !== 1'b1) begin n_bad++; $display("FAIL rst_banks: got rd=%b wr=%b expected rd=0 wr=1", rd_bank, wr_bank); end
    n_cmp++; if (result_bank !== 1'b0) begin n_bad++; $display("FAIL rst_result_bank: got %b expected 0", result_bank); end
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_stays: got busy=%b expected 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    int bad, cnt_iv, cnt_wb, cnt_done;
    run(1070, -1, -1, -1, -1, -1, -1);
    bad = 0;
    for (int c = 1; c <= 128; c++) if (ob_iv[c] !== 1'b1 || ob_idx[c] !== 7'(c - 1)) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL nom_issue_window: got %0d bad cycles expected 0", bad); end
    bad = 0;
    for (int c = 129; c <= 133; c++) if (ob_iv[c] !== 1'b0) bad++;
    if (ob_iv[0] !== 1'b0) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL nom_no_issue_outside: got %0d bad cycles expected 0", bad); end
    n_cmp++; if (ob_stage[132] !== 5'd1 || ob_stage[133] !== 5'd2) begin n_bad++; $display("FAIL nom_stage2_at_133: got %0d,%0d expected 1,2", ob_stage[132], ob_stage[133]); end
    n_cmp++; if (ob_iv[134] !== 1'b1 || ob_idx[134] !== 7'd0 || ob_stage[134] !== 5'd2) begin n_bad++; $display("FAIL nom_stage2_first_issue: got iv=%b idx=%0d st=%0d expected 1,0,2", ob_iv[134], ob_idx[134], ob_stage[134]); end
    n_cmp++; if (ob_wb[132] !== 1'b1 || ob_wbidx[132] !== 7'd127 || ob_wb[133] !== 1'b0) begin n_bad++; $display("FAIL nom_last_wb_stage1: got wb=%b idx=%0d next=%b expected 1,127,0", ob_wb[132], ob_wbidx[132], ob_wb[133]); end
    cnt_iv = 0; cnt_wb = 0; cnt_done = 0;
    for (int c = 0; c < 1070; c++) begin
      if (ob_iv[c] === 1'b1) cnt_iv++;
      if (ob_wb[c] === 1'b1) cnt_wb++;
      if (ob_done[c] === 1'b1) cnt_done++;
    end
    n_cmp++; if (cnt_iv != 1024) begin n_bad++; $display("FAIL nom_issue_count: got %0d expected 1024", cnt_iv); end
    n_cmp++; if (cnt_wb != 1024) begin n_bad++; $display("FAIL nom_wb_count: got %0d expected 1024", cnt_wb); end
    n_cmp++; if (cnt_done != 1 || ob_done[1064] !== 1'b1) begin n_bad++; $display("FAIL nom_done_1064: got count=%0d at1064=%b expected 1,1", cnt_done, ob_done[1064]); end
    n_cmp++; if (ob_busy[1] !== 1'b1 || ob_busy[1064] !== 1'b1 || ob_busy[1065] !== 1'b0) begin n_bad++; $display("FAIL nom_busy: got %b%b%b expected 110", ob_busy[1], ob_busy[1064], ob_busy[1065]); end
    n_cmp++; if (ob_rb[1064] !== 1'b0 || ob_rb[1069] !== 1'b0) begin n_bad++; $display("FAIL nom_result_bank: got %b,%b expected 0,0", ob_rb[1064], ob_rb[1069]); end
    bad = 0;
    for (int c = 4; c < 1070; c++) begin
      if (ob_wb[c] !== ob_iv[c-4]) bad++;
      else if (ob_wb[c] === 1'b1 && ob_wbidx[c] !== ob_idx[c-4]) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL nom_wb_delay4: got %0d bad cycles expected 0", bad); end
    // Twiddles: stage 3 issues from cycle 267, stage 8 from cycle 932.
    n_cmp++; if (ob_tw[6] !== 8'd1) begin n_bad++; $display("FAIL tw_s1_j5: got %0d expected 1", ob_tw[6]); end
    n_cmp++; if (ob_tw[267] !== 8'd4) begin n_bad++; $display("FAIL tw_s3_j0: got %0d expected 4", ob_tw[267]); end
    n_cmp++; if (ob_tw[298] !== 8'd4) begin n_bad++; $display("FAIL tw_s3_j31: got %0d expected 4", ob_tw[298]); end
    n_cmp++; if (ob_tw[299] !== 8'd5) begin n_bad++; $display("FAIL tw_s3_j32: got %0d expected 5", ob_tw[299]); end
    n_cmp++; if (ob_tw[394] !== 8'd7 || ob_stage[394] !== 5'd3) begin n_bad++; $display("FAIL tw_s3_j127: got %0d st=%0d expected 7 st=3", ob_tw[394], ob_stage[394]); end
    n_cmp++; if (ob_tw[932] !== 8'd128) begin n_bad++; $display("FAIL tw_s8_j0: got %0d expected 128", ob_tw[932]); end
    n_cmp++; if (ob_tw[1059] !== 8'd255 || ob_idx[1059] !== 7'd127 || ob_stage[1059] !== 5'd8) begin n_bad++; $display("FAIL tw_s8_j127: got %0d expected 255", ob_tw[1059]); end
    n_cmp++; if (ob_rd[1] !== 1'b0 || ob_rd[134] !== 1'b1 || ob_rd[267] !== 1'b0 || ob_rd[932] !== 1'b1) begin n_bad++; $display("FAIL bank_pingpong: got %b%b%b%b expected 0101", ob_rd[1], ob_rd[134], ob_rd[267], ob_rd[932]); end
    bad = 0;
    for (int c = 0; c < 1070; c++) begin
      if (ob_wr[c] !== ~ob_rd[c]) bad++;
      if (ob_busy[c] === 1'b1 && ob_rd[c] !== ~ob_stage[c][0]) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bank_per_stage: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_hold();
    int bad, cnt_wb, cnt_done;
    do_reset();
    run(1075, 10, 14, -1, -1, -1, -1);
    bad = 0;
    for (int c = 10; c <= 14; c++) if (ob_iv[c] !== 1'b0 || ob_idx[c] !== 7'd9) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL hold_frozen: got %0d bad cycles expected 0", bad); end
    n_cmp++; if (ob_iv[9] !== 1'b1 || ob_idx[9] !== 7'd8 || ob_iv[15] !== 1'b1 || ob_idx[15] !== 7'd9) begin n_bad++; $display("FAIL hold_edges: got idx9=%0d idx15=%0d expected 8,9", ob_idx[9], ob_idx[15]); end
    n_cmp++; if (ob_wb[13] !== 1'b1 || ob_wb[16] !== 1'b0 || ob_wb[19] !== 1'b1 || ob_wbidx[19] !== 7'd9) begin n_bad++; $display("FAIL hold_wb_gap: got %b%b%b idx=%0d expected 101 idx=9", ob_wb[13], ob_wb[16], ob_wb[19], ob_wbidx[19]); end
    bad = 0; cnt_wb = 0; cnt_done = 0;
    for (int c = 0; c < 1075; c++) begin
      if (c >= 4 && (ob_wb[c] !== ob_iv[c-4])) bad++;
      if (ob_wb[c] === 1'b1) cnt_wb++;
      if (ob_done[c] === 1'b1) cnt_done++;
    end
    n_cmp++; if (bad != 0 || cnt_wb != 1024) begin n_bad++; $display("FAIL hold_wb_delay: got bad=%0d count=%0d expected 0,1024", bad, cnt_wb); end
    n_cmp++; if (cnt_done != 1 || ob_done[1069] !== 1'b1 || ob_busy[1070] !== 1'b0) begin n_bad++; $display("FAIL hold_done_1069: got count=%0d at1069=%b expected 1,1", cnt_done, ob_done[1069]); end
  endtask

  task automatic test_start_while_busy();
    int cnt_done;
    do_reset();
    run(1070, -1, -1, 50, 900, 1065, -1);
    n_cmp++; if (ob_idx[50] !== 7'd49 || ob_idx[51] !== 7'd50 || ob_stage[51] !== 5'd1) begin n_bad++; $display("FAIL sb_c50: got idx=%0d,%0d expected 49,50", ob_idx[50], ob_idx[51]); end
    n_cmp++; if (ob_stage[901] !== 5'd7 || ob_idx[901] !== 7'd102 || ob_iv[901] !== 1'b1) begin n_bad++; $display("FAIL sb_c900: got st=%0d idx=%0d expected 7,102", ob_stage[901], ob_idx[901]); end
    cnt_done = 0;
    for (int c = 0; c < 1070; c++) if (ob_done[c] === 1'b1) cnt_done++;
    n_cmp++; if (cnt_done != 1 || ob_done[1064] !== 1'b1) begin n_bad++; $display("FAIL sb_done_1064: got count=%0d at1064=%b expected 1,1", cnt_done, ob_done[1064]); end
    n_cmp++; if (ob_busy[1065] !== 1'b0 || ob_iv[1065] !== 1'b0) begin n_bad++; $display("FAIL sb_idle_1065: got busy=%b iv=%b expected 0,0", ob_busy[1065], ob_iv[1065]); end
    n_cmp++; if (ob_iv[1066] !== 1'b1 || ob_idx[1066] !== 7'd0 || ob_stage[1066] !== 5'd1 || ob_rd[1066] !== 1'b0) begin n_bad++; $display("FAIL back_to_back_1066: got iv=%b idx=%0d st=%0d rd=%b expected 1,0,1,0", ob_iv[1066], ob_idx[1066], ob_stage[1066], ob_rd[1066]); end
  endtask

  task automatic test_reset_mid_run();
    int cnt_wb, cnt_done;
    do_reset();
    run(410, -1, -1, -1, -1, -1, 400);
    n_cmp++; if (ob_stage[400] !== 5'd4 || ob_iv[400] !== 1'b1 || ob_idx[400] !== 7'd0) begin n_bad++; $display("FAIL rm_c400: got st=%0d iv=%b expected 4,1", ob_stage[400], ob_iv[400]); end
    n_cmp++; if (ob_busy[401] !== 1'b0 || ob_iv[401] !== 1'b0 || ob_wb[401] !== 1'b0) begin n_bad++; $display("FAIL rm_abort: got busy=%b iv=%b wb=%b expected 0,0,0", ob_busy[401], ob_iv[401], ob_wb[401]); end
    n_cmp++; if (ob_stage[401] !== 5'd1 || ob_rd[401] !== 1'b0 || ob_idx[401] !== 7'd0) begin n_bad++; $display("FAIL rm_state: got st=%0d rd=%b idx=%0d expected 1,0,0", ob_stage[401], ob_rd[401], ob_idx[401]); end
    cnt_wb = 0; cnt_done = 0;
    for (int c = 401; c < 410; c++) if (ob_wb[c] === 1'b1) cnt_wb++;
    for (int c = 0; c < 410; c++) if (ob_done[c] === 1'b1) cnt_done++;
    n_cmp++; if (cnt_wb != 0) begin n_bad++; $display("FAIL rm_inflight_dropped: got %0d wb pulses expected 0", cnt_wb); end
    n_cmp++; if (cnt_done != 0 || ob_busy[409] !== 1'b0) begin n_bad++; $display("FAIL rm_no_done: got %0d done pulses busy=%b expected 0,0", cnt_done, ob_busy[409]); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; hold = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_nominal();
    test_hold();
    test_start_while_busy();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ntt_stage_ctrl.md
Name: ntt_stage_ctrl

Overview:
- Top-level sequencer for the in-place NTT datapath.
- On `start`, steps through stages 1..LOGN and issues N/2 butterfly slots per stage to the BFU pipeline.
- Waits for the pipeline to drain after each stage, then swaps the ping-pong RAM bank roles and moves to the next stage.
- Supplies stage index, butterfly index, twiddle address and bank selects to the address generator and RAMs; pulses `done` once the transform completes.

Parameters:
- LOGN, 8, log2 of ring size; N = 2^LOGN (256 by default).
- BFU_LAT, 4, butterfly pipeline latency in cycles, issue to write-back (must be >= 1).
- AW, LOGN-1, width of the butterfly index.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request a transform; sampled only in IDLE.
- hold  in  1  stall issue this cycle; honoured only in ISSUE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last stage has drained.
- stage  out  5  current stage, 1..LOGN.
- bfly_idx  out  AW  butterfly slot being issued.
- issue_valid  out  1  a butterfly is issued this cycle.
- tw_addr  out  LOGN  twiddle ROM address for the issued butterfly.
- wb_valid  out  1  `issue_valid` delayed by BFU_LAT cycles.
- wb_idx  out  AW  `bfly_idx` delayed by BFU_LAT cycles.
- rd_bank  out  1  RAM bank read in the current stage.
- wr_bank  out  1  always equal to ~rd_bank.
- result_bank  out  1  bank holding the final result; valid while `done`=1 and after.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE, stage=1, bfly_idx=0, rd_bank=0, drain counter=0, delay line cleared.
  - Outputs: issue_valid=0, wb_valid=0, done=0, busy=0, tw_addr=0, wb_idx=0, result_bank=LOGN[0].
  - Reset applied mid-operation aborts immediately. No done pulse. In-flight wb_valid entries are discarded.
- IDLE:
  - start=1 -> ISSUE next cycle, with stage=1, bfly_idx=0, rd_bank=0.
  - start=0 -> remain in IDLE.
- ISSUE:
  - hold=0: issue_valid=1 combinationally; bfly_idx advances by 1 at the edge.
  - hold=1: issue_valid=0; bfly_idx holds its value.
  - On the edge that issues bfly_idx=N/2-1: go to DRAIN and clear bfly_idx to 0.
- Twiddle address:
  - tw_addr = (1 << (stage-1)) + (bfly_idx >> (LOGN-stage)).
  - Computed in LOGN bits; the result never exceeds N-1.
- Write-back delay line:
  - Shift register of depth BFU_LAT carrying {issue_valid, bfly_idx}.
  - Shifts every cycle regardless of state or hold.
- DRAIN:
  - Counts BFU_LAT cycles. The last write-back (wb_valid=1) falls on the final DRAIN cycle.
  - Then: if stage==LOGN -> DONE, else -> NEXT.
- NEXT (exactly one cycle): stage increments, rd_bank toggles, then -> ISSUE.
- DONE (exactly one cycle): done=1, busy=1, then -> IDLE.
- start while busy=1: ignored, with no effect on any counter.
- hold while not in ISSUE: ignored.
- Total latency with hold=0 throughout:
  - Per stage: N/2 + BFU_LAT + 1 cycles (133 cycles at defaults), including the NEXT cycle.
  - The final stage skips NEXT; DONE follows DRAIN.
  - Defaults: first issue in cycle 1 after start is sampled; done=1 in cycle 1064; back in IDLE in cycle 1065.
  - Each cycle of hold=1 in ISSUE adds exactly one cycle.

Decomposition:
- defines.v gains:
  - `Ringsize, `Stagebnum (=N/2), `BfuLat.
  - State encodings: IDLE=0, ISSUE=1, DRAIN=2, NEXT=3, DONE=4 (3-bit).
- One sub-module, `wb_delay_line`:
  - Parameterised depth and width; synchronous active-low clear.
  - Instantiated once for {valid, idx}.
- FSM, counters and twiddle arithmetic stay in ntt_stage_ctrl.

Test Plan:
- Nominal: reset, start pulse at cycle 0, hold=0 (N=256, BFU_LAT=4) -> issue_valid high in cycles 1..128 with bfly_idx 0..127; stage=2 from cycle 133; done only in cycle 1064; result_bank=0; exactly 1024 wb_valid pulses total.
- Twiddle check: in stage 3, bfly_idx=0,31,32,127 -> tw_addr = 4,4,5,7; in stage 8, bfly_idx=127 -> tw_addr=255.
- Hold: hold=1 for cycles 10..14 of stage 1 -> issue_valid=0 and bfly_idx frozen at 9; done moves to cycle 1069; wb_valid is still exactly 4 cycles after each issue.
- Start while busy: start pulses at cycles 50 and 900 -> no change in counters, stage or done timing; a second start in cycle 1065 (IDLE) begins a new run with first issue in cycle 1066.
- Reset mid-run: reset=0 at cycle 400 (stage 4) -> next cycle busy=0, issue_valid=0, wb_valid=0, stage=1, rd_bank=0; no done pulse.
- Bank ping-pong: rd_bank=0 in stage 1, 1 in stage 2, alternating thereafter; wr_bank always equals ~rd_bank.
